// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and parity helper.
// Imported by both the transmitter and the receiver so their framing agrees.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic uart_parity(
        input logic [UART_DATA_BITS-1:0] data,
        input logic                      even
    );
        return even ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BRCLOCK_CYCLES-1, wraps, flags terminal count.
// A synchronous clear holds it at zero while the line is idle.
module uart_baud_gen #(
    parameter int BRCLOCK_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BRCLOCK_CYCLES > 1) ? $clog2(BRCLOCK_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(BRCLOCK_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == TC);

    // Count up, wrapping at terminal count; clear restarts the bit period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, stop.
// Frame fields are latched at accept so inputs may change mid-frame.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int BRCLOCK_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       pen,
    input  logic       peven,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    uart_state_t state, state_n;
    logic [UART_DATA_BITS-1:0] data_q, data_n;
    logic       pen_q, pen_n;
    logic       par_q, par_n;
    logic [2:0] idx, idx_n;
    logic       tx_n, busy_n, done_n;
    logic       tick;

    uart_baud_gen #(
        .BRCLOCK_CYCLES(BRCLOCK_CYCLES)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            data_q <= '0;
            pen_q  <= 1'b0;
            par_q  <= 1'b0;
            idx    <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            pen_q  <= pen_n;
            par_q  <= par_n;
            idx    <= idx_n;
            tx     <= tx_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state logic; tx is computed for the state being entered.
    always_comb begin
        state_n = state;
        data_n  = data_q;
        pen_n   = pen_q;
        par_n   = par_q;
        idx_n   = idx;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    data_n  = din;
                    pen_n   = pen;
                    par_n   = uart_parity(din, peven);
                    idx_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_n   = '0;
                    tx_n    = data_q[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == 3'd7) begin
                        if (pen_q) begin
                            tx_n    = par_q;
                            state_n = PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end
                    end else begin
                        idx_n = idx + 3'd1;
                        tx_n  = data_q[idx + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed table, corner sequences,
// and randomized frames checked cycle-by-cycle against a frame-level model.
module tb_uart_transmitter;

    localparam int BR = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       pen;
    logic       peven;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       pe;
        logic       ep;
    } vec_t;

    vec_t tbl[4];

    uart_transmitter #(
        .BRCLOCK_CYCLES(BR)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din),
        .pen  (pen),
        .peven(peven),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected line level for bit slot j of a frame, from the frame format.
    function automatic logic exp_bit(input logic [7:0] d, input logic p,
                                     input logic pe, input int j);
        int ones;
        ones = $countones(d);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (j == 9 && p) begin
            if (pe) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle).
    // Returns at the negedge of the done cycle.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic pe, input bit hold,
                              input logic [7:0] d2, output logic par_seen);
        int len;
        int b;
        logic [7:0] rx;
        logic rpar;
        rx = '0;
        rpar = 1'b0;
        len = (p ? 11 : 10) * BR;
        start = 1'b1;
        din = d;
        pen = p;
        peven = pe;
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            b = (k - 1) / BR;
            chk("tx", tx, exp_bit(d, p, pe, b));
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            if ((k - 1) % BR == BR / 2) begin
                if (b >= 1 && b <= 8) rx[b-1] = tx;
                if (b == 9 && p) rpar = tx;
            end
            if (hold) begin
                start = 1'b1;
                din = d2;
                pen = 1'b0;
                peven = 1'b0;
            end else begin
                start = 1'b0;
                din = 8'($urandom);
                pen = 1'($urandom);
                peven = 1'($urandom);
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_tx", tx, 1);
        chk("rx_byte", rx, d);
        if (p) chk("rx_parity_ok", ($countones({rx, rpar}) % 2), pe ? 0 : 1);
        par_seen = rpar;
    endtask

    initial begin
        logic ps;
        tbl[0] = '{d: 8'hA5, p: 1'b0, pe: 1'b0, ep: 1'b1};
        tbl[1] = '{d: 8'hA5, p: 1'b1, pe: 1'b1, ep: 1'b0};
        tbl[2] = '{d: 8'hA5, p: 1'b1, pe: 1'b0, ep: 1'b1};
        tbl[3] = '{d: 8'h07, p: 1'b1, pe: 1'b1, ep: 1'b1};

        rst = 1'b0;
        start = 1'b0;
        din = '0;
        pen = 1'b0;
        peven = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        idle_check(100);

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].pe, 0, 8'h00, ps);
            if (tbl[i].p) chk("par_bit", ps, tbl[i].ep);
            idle_check(3);
        end

        send_frame(8'h5A, 1'b0, 1'b0, 1, 8'h3C, ps);
        send_frame(8'h3C, 1'b0, 1'b0, 0, 8'h00, ps);
        idle_check(2);

        start = 1'b1;
        din = 8'h5A;
        pen = 1'b0;
        peven = 1'b0;
        @(posedge clk);
        for (int k = 1; k < 45; k++) begin
            @(negedge clk);
            start = 1'b0;
            din = 8'($urandom);
        end
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b1;
        idle_check(120);
        send_frame(8'h81, 1'b0, 1'b0, 0, 8'h00, ps);
        idle_check(2);

        for (int i = 0; i < 256; i++) begin
            logic p;
            logic pe;
            p = 1'($urandom);
            pe = 1'($urandom);
            send_frame(8'(i), p, pe, 0, 8'h00, ps);
            idle_check(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
